// File: rtl/seq_sm_mult.sv
// Sequential sign-magnitude multiplier: one multiplier bit per clock, shift-and-add,
// with a valid/ready handshake on both the operand and the result side.
`timescale 1ns/1ps

module seq_sm_mult #(
    parameter int WIDTH    = 8,
    parameter bit SATURATE = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] product,
    output logic             overflow,
    output logic             busy
);

    localparam int MW = WIDTH - 1;
    localparam int AW = 2 * MW;
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(MW - 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t           state_reg, state_next;
    logic [AW-1:0]    mcand_reg, mcand_next;
    logic [AW-1:0]    acc_reg, acc_next;
    logic [MW-1:0]    mplier_reg, mplier_next;
    logic             sign_reg, sign_next;
    logic [CW-1:0]    cnt_reg, cnt_next;
    logic [WIDTH-1:0] product_reg, product_next;
    logic             overflow_reg, overflow_next;

    logic [AW-1:0]    acc_sum;
    logic             sum_ovf;
    logic [MW-1:0]    sum_mag;
    logic             zero_op;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            mcand_reg    <= '0;
            acc_reg      <= '0;
            mplier_reg   <= '0;
            sign_reg     <= 1'b0;
            cnt_reg      <= '0;
            product_reg  <= '0;
            overflow_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            mcand_reg    <= mcand_next;
            acc_reg      <= acc_next;
            mplier_reg   <= mplier_next;
            sign_reg     <= sign_next;
            cnt_reg      <= cnt_next;
            product_reg  <= product_next;
            overflow_reg <= overflow_next;
        end
    end

    always_comb begin
        // The multiplicand shifts left and the multiplier shifts right, so each
        // CALC step only looks at mplier_reg[0]; the accumulator is wide enough to never wrap.
        acc_sum       = acc_reg + (mplier_reg[0] ? mcand_reg : '0);
        sum_ovf       = |acc_sum[AW-1:MW];
        sum_mag       = (sum_ovf && SATURATE) ? '1 : acc_sum[MW-1:0];
        zero_op       = (a[MW-1:0] == '0) || (b[MW-1:0] == '0);

        state_next    = state_reg;
        mcand_next    = mcand_reg;
        acc_next      = acc_reg;
        mplier_next   = mplier_reg;
        sign_next     = sign_reg;
        cnt_next      = cnt_reg;
        product_next  = product_reg;
        overflow_next = overflow_reg;

        case (state_reg)
            IDLE: begin
                if (in_valid) begin
                    mcand_next  = {{MW{1'b0}}, a[MW-1:0]};
                    mplier_next = b[MW-1:0];
                    sign_next   = a[WIDTH-1] ^ b[WIDTH-1];
                    acc_next    = '0;
                    cnt_next    = '0;
                    if (zero_op) begin
                        product_next  = '0;
                        overflow_next = 1'b0;
                        state_next    = DONE;
                    end else begin
                        state_next    = CALC;
                    end
                end
            end
            CALC: begin
                acc_next    = acc_sum;
                mcand_next  = mcand_reg << 1;
                mplier_next = mplier_reg >> 1;
                cnt_next    = cnt_reg + CW'(1);
                if (cnt_reg == LAST_BIT) begin
                    overflow_next = sum_ovf;
                    // A zero magnitude is always reported as +0.
                    product_next  = (sum_mag == '0) ? '0 : {sign_reg, sum_mag};
                    state_next    = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign in_ready  = (state_reg == IDLE);
    assign out_valid = (state_reg == DONE);
    assign busy      = (state_reg != IDLE);
    assign product   = product_reg;
    assign overflow  = overflow_reg;

endmodule

// File: tb/tb_seq_sm_mult.sv
// Directed bench for seq_sm_mult: WIDTH=8 saturating and truncating instances share
// stimulus; a WIDTH=16 instance is swept with random operands against a golden multiply.
`timescale 1ns/1ps

module tb_seq_sm_mult;

    logic        clk;
    logic        rst_n;

    logic        iv8, or8;
    logic [7:0]  a8, b8;
    logic        ir_s, ov_s, of_s, bz_s;
    logic [7:0]  p_s;
    logic        ir_t, ov_t, of_t, bz_t;
    logic [7:0]  p_t;

    logic        iv16, or16;
    logic [15:0] a16, b16;
    logic        ir16, ov16, of16, bz16;
    logic [15:0] p16;

    int checks;
    int errors;

    seq_sm_mult #(.WIDTH(8), .SATURATE(1'b1)) dut_sat (
        .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir_s), .a(a8), .b(b8),
        .out_valid(ov_s), .out_ready(or8), .product(p_s), .overflow(of_s), .busy(bz_s)
    );

    seq_sm_mult #(.WIDTH(8), .SATURATE(1'b0)) dut_trunc (
        .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir_t), .a(a8), .b(b8),
        .out_valid(ov_t), .out_ready(or8), .product(p_t), .overflow(of_t), .busy(bz_t)
    );

    seq_sm_mult #(.WIDTH(16), .SATURATE(1'b1)) dut_w16 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16), .a(a16), .b(b16),
        .out_valid(ov16), .out_ready(or16), .product(p16), .overflow(of16), .busy(bz16)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One WIDTH=8 transaction with out_ready held high; operands are scrambled after accept.
    task automatic run8(input logic [7:0] ta, input logic [7:0] tbv, input logic [7:0] eps,
                        input logic [7:0] ept, input logic eo, input string tag);
        int lat;
        int exp_lat;
        @(negedge clk);
        iv8 = 1'b1; a8 = ta; b8 = tbv; or8 = 1'b1;
        check({tag, ".in_ready"}, ir_s, 1);
        @(posedge clk); #1;
        iv8 = 1'b0; a8 = ~ta; b8 = ~tbv;
        lat = 0;
        while (!ov_s && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        exp_lat = (ta[6:0] == 7'd0 || tbv[6:0] == 7'd0) ? 0 : 7;
        check({tag, ".latency"}, lat, exp_lat);
        check({tag, ".sat_product"}, p_s, eps);
        check({tag, ".sat_overflow"}, of_s, eo);
        check({tag, ".trunc_valid"}, ov_t, 1);
        check({tag, ".trunc_product"}, p_t, ept);
        check({tag, ".trunc_overflow"}, of_t, eo);
        $display("txn %s a=%h b=%h sat=%h trunc=%h ovf=%b lat=%0d", tag, ta, tbv, p_s, p_t, of_s, lat);
        @(posedge clk); #1;
        check({tag, ".back_to_idle"}, {ir_s, ov_s}, 2'b10);
    endtask

    function automatic logic [16:0] gold16(input logic [15:0] x, input logic [15:0] y);
        logic [29:0] full;
        logic [14:0] mag;
        logic        ovf;
        full = 30'(x[14:0]) * 30'(y[14:0]);
        ovf  = |full[29:15];
        mag  = ovf ? 15'h7fff : full[14:0];
        return {ovf, (mag == 15'd0) ? 16'h0000 : {x[15] ^ y[15], mag}};
    endfunction

    task automatic run16(input logic [15:0] x, input logic [15:0] y, input int idx);
        int          lat;
        int          exp_lat;
        logic [16:0] g;
        g = gold16(x, y);
        exp_lat = (x[14:0] == 15'd0 || y[14:0] == 15'd0) ? 0 : 15;
        @(negedge clk);
        iv16 = 1'b1; a16 = x; b16 = y;
        check("w16.in_ready", ir16, 1);
        @(posedge clk); #1;
        iv16 = 1'b0; a16 = ~x; b16 = ~y;
        check("w16.busy", bz16, 1);
        lat = 0;
        while (!ov16 && lat < 60) begin
            @(posedge clk); #1;
            lat++;
        end
        check("w16.latency", lat, exp_lat);
        check("w16.product", p16, g[15:0]);
        check("w16.overflow", of16, g[16]);
        $display("txn w16 #%0d a=%h b=%h product=%h ovf=%b lat=%0d", idx, x, y, p16, of16, lat);
        @(posedge clk); #1;
    endtask

    initial begin
        int          n;
        int          seen;
        logic [15:0] x, y;
        checks = 0;
        errors = 0;
        iv8 = 1'b0; or8 = 1'b1; a8 = '0; b8 = '0;
        iv16 = 1'b0; or16 = 1'b1; a16 = '0; b16 = '0;

        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        check("reset.in_ready", ir_s, 1);
        check("reset.out_valid", ov_s, 0);
        check("reset.busy", bz_s, 0);
        check("reset.product", p_s, 0);
        check("reset.overflow", of_s, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        //    a      b      sat    trunc  ovf
        run8(8'h05, 8'h83, 8'h8F, 8'h8F, 1'b0, "basic");
        run8(8'h40, 8'h02, 8'h7F, 8'h00, 1'b1, "sat_pos");
        run8(8'hC0, 8'h02, 8'hFF, 8'h00, 1'b1, "sat_neg");
        run8(8'h41, 8'h82, 8'hFF, 8'h82, 1'b1, "trunc_neg");
        run8(8'h80, 8'h85, 8'h00, 8'h00, 1'b0, "zero_negzero");
        run8(8'h7F, 8'h7F, 8'h7F, 8'h01, 1'b1, "max_max");
        run8(8'hFF, 8'h81, 8'h7F, 8'h7F, 1'b0, "neg_neg");
        run8(8'h0B, 8'h8B, 8'hF9, 8'hF9, 1'b0, "eleven_sq");
        run8(8'h03, 8'h00, 8'h00, 8'h00, 1'b0, "zero_b");
        run8(8'h8A, 8'h0C, 8'hF8, 8'hF8, 1'b0, "ten_twelve");
        run8(8'h90, 8'h88, 8'h7F, 8'h00, 1'b1, "just_over");
        run8(8'h81, 8'hC0, 8'h40, 8'h40, 1'b0, "one_times");

        // Backpressure: result must hold while out_ready is low and inputs churn.
        @(negedge clk);
        iv8 = 1'b1; a8 = 8'h05; b8 = 8'h83; or8 = 1'b0;
        @(posedge clk); #1;
        iv8 = 1'b0;
        n = 0;
        while (!ov_s && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check("bp.latency", n, 7);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            iv8 = 1'b1; a8 = 8'h7F; b8 = 8'h7F;
            check("bp.out_valid", ov_s, 1);
            check("bp.product", p_s, 8'h8F);
            check("bp.overflow", of_s, 0);
            check("bp.in_ready", ir_s, 0);
            $display("txn bp hold %0d product=%h out_valid=%b in_ready=%b", k, p_s, ov_s, ir_s);
        end
        @(negedge clk);
        iv8 = 1'b1; a8 = 8'h02; b8 = 8'h03; or8 = 1'b1;
        @(posedge clk); #1;
        check("done_to_idle.not_accepted", {ir_s, ov_s, bz_s}, 3'b100);
        @(posedge clk); #1;
        iv8 = 1'b0;
        check("done_to_idle.accept_next", bz_s, 1);
        n = 0;
        while (!ov_s && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check("done_to_idle.latency", n, 7);
        check("done_to_idle.product", p_s, 8'h06);
        $display("txn late_accept a=02 b=03 product=%h lat=%0d", p_s, n);
        @(posedge clk); #1;

        // Reset in the middle of CALC, then confirm no result ever appears.
        @(negedge clk);
        iv8 = 1'b1; a8 = 8'h05; b8 = 8'h83;
        @(posedge clk); #1;
        iv8 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("abort.in_calc", bz_s, 1);
        rst_n = 1'b0;
        #1;
        check("abort.in_ready", {ir_s, ir_t}, 2'b11);
        check("abort.out_valid", {ov_s, ov_t}, 2'b00);
        check("abort.product", {p_s, p_t}, 16'h0000);
        check("abort.overflow", {of_s, of_t}, 2'b00);
        check("abort.busy", {bz_s, bz_t}, 2'b00);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (ov_s || ov_t) seen++;
        end
        check("abort.no_result", seen, 0);
        $display("txn abort mid-calc out_valid_seen=%0d", seen);

        // Operands presented as reset releases are taken on the very first edge.
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1; iv8 = 1'b1; a8 = 8'h03; b8 = 8'h85;
        @(posedge clk); #1;
        iv8 = 1'b0;
        check("post_reset.accept", bz_s, 1);
        n = 0;
        while (!ov_s && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check("post_reset.latency", n, 7);
        check("post_reset.product", p_s, 8'h8F);
        $display("txn post_reset a=03 b=85 product=%h lat=%0d", p_s, n);
        @(posedge clk); #1;

        for (int i = 0; i < 1000; i++) begin
            x = 16'($urandom);
            y = 16'($urandom);
            if (i % 4 == 1) begin
                x[14:7] = 8'd0;
                y[14:7] = 8'd0;
            end
            if (i % 40 == 2) x[14:0] = 15'd0;
            if (i % 40 == 3) y[14:0] = 15'd0;
            run16(x, y, i);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
